// File: rtl/bram_dp_clr.sv
// Dual-port block RAM: port A read/write with byte lanes and selectable
// read-during-write behaviour, port B read-only, clear sequencer after reset.
module bram_dp_clr #(
   parameter int AWIDTH = 4,
   parameter int DWIDTH = 8,
   parameter int BWIDTH = 8,
   parameter int WRMODE = 0,
   parameter int OUT_REG = 0,
   parameter logic [DWIDTH-1:0] CLR_VALUE = '0,
   localparam int NB = DWIDTH / BWIDTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_en,
   input  logic [NB-1:0]     a_we,
   input  logic [AWIDTH-1:0] a_addr,
   input  logic [DWIDTH-1:0] a_din,
   output logic [DWIDTH-1:0] a_dout,
   input  logic              b_en,
   input  logic [AWIDTH-1:0] b_addr,
   output logic [DWIDTH-1:0] b_dout,
   output logic              busy
);

   // state | meaning
   // CLEAR | sequencer writes CLR_VALUE to every word; ports ignored
   // READY | normal dual-port operation

   localparam int DEPTH = 2 ** AWIDTH;

   typedef enum logic {CLEAR, READY} state_t;

   state_t            state, state_nxt;
   logic [AWIDTH-1:0] clr_cnt;
   logic [DWIDTH-1:0] mem [DEPTH];
   logic [DWIDTH-1:0] a_old, a_merged;
   logic [DWIDTH-1:0] a_q, b_q;
   logic              clr_last;

   assign clr_last = (clr_cnt == AWIDTH'(DEPTH - 1));
   assign a_old    = mem[a_addr];

   always_comb begin
      state_nxt = state;
      case (state)
         CLEAR:   if (clr_last) state_nxt = READY;
         READY:   state_nxt = READY;
         default: state_nxt = CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= CLEAR;
         busy    <= 1'b1;
         clr_cnt <= '0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt == CLEAR);
         if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
      end
   end

   // Word as it will look after this cycle's port A write
   always_comb begin
      a_merged = a_old;
      for (int i = 0; i < NB; i++)
         if (a_we[i]) a_merged[i*BWIDTH +: BWIDTH] = a_din[i*BWIDTH +: BWIDTH];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == CLEAR)
            mem[clr_cnt] <= CLR_VALUE;
         else if (a_en) begin
            for (int i = 0; i < NB; i++)
               if (a_we[i]) mem[a_addr][i*BWIDTH +: BWIDTH] <= a_din[i*BWIDTH +: BWIDTH];
         end
      end
   end

   // Port B reads the array before the same-edge write lands, so a
   // collision returns the old word.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q <= '0;
         b_q <= '0;
      end else if (state == READY) begin
         if (a_en) begin
            if (WRMODE == 1)
               a_q <= a_merged;
            else if (WRMODE == 2) begin
               if (a_we == '0) a_q <= a_old;
            end else
               a_q <= a_old;
         end
         if (b_en) b_q <= mem[b_addr];
      end
   end

   generate
      if (OUT_REG != 0) begin : g_oreg
         logic [DWIDTH-1:0] a_q2, b_q2;
         always_ff @(posedge clk) begin
            if (rst) begin
               a_q2 <= '0;
               b_q2 <= '0;
            end else begin
               a_q2 <= a_q;
               b_q2 <= b_q;
            end
         end
         assign a_dout = a_q2;
         assign b_dout = b_q2;
      end else begin : g_noreg
         assign a_dout = a_q;
         assign b_dout = b_q;
      end
   endgenerate

endmodule

// File: tb/tb_bram_dp_clr.sv
// Bench for bram_dp_clr: three 8-bit instances (one per read-during-write
// mode) and two 16-bit byte-lane instances, with and without output register.
module tb_bram_dp_clr;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_en, b_en;
   logic [3:0]  a_addr, b_addr;
   logic [0:0]  a_we8;
   logic [7:0]  a_din8;
   logic [1:0]  a_we16;
   logic [15:0] a_din16;

   logic [7:0]  a_rf, a_wf, a_nc, b_rf, b_wf, b_nc;
   logic        busy_rf, busy_wf, busy_nc;
   logic [15:0] a_w0, a_w1, b_w0, b_w1;
   logic        busy_w0, busy_w1;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   bram_dp_clr #(.AWIDTH(4), .DWIDTH(8), .BWIDTH(8), .WRMODE(0), .OUT_REG(0), .CLR_VALUE(8'hA5))
      u_rf (.clk(clk), .rst(rst), .a_en(a_en), .a_we(a_we8), .a_addr(a_addr), .a_din(a_din8),
            .a_dout(a_rf), .b_en(b_en), .b_addr(b_addr), .b_dout(b_rf), .busy(busy_rf));
   bram_dp_clr #(.AWIDTH(4), .DWIDTH(8), .BWIDTH(8), .WRMODE(1), .OUT_REG(0), .CLR_VALUE(8'hA5))
      u_wf (.clk(clk), .rst(rst), .a_en(a_en), .a_we(a_we8), .a_addr(a_addr), .a_din(a_din8),
            .a_dout(a_wf), .b_en(b_en), .b_addr(b_addr), .b_dout(b_wf), .busy(busy_wf));
   bram_dp_clr #(.AWIDTH(4), .DWIDTH(8), .BWIDTH(8), .WRMODE(2), .OUT_REG(0), .CLR_VALUE(8'hA5))
      u_nc (.clk(clk), .rst(rst), .a_en(a_en), .a_we(a_we8), .a_addr(a_addr), .a_din(a_din8),
            .a_dout(a_nc), .b_en(b_en), .b_addr(b_addr), .b_dout(b_nc), .busy(busy_nc));
   bram_dp_clr #(.AWIDTH(4), .DWIDTH(16), .BWIDTH(8), .WRMODE(0), .OUT_REG(0), .CLR_VALUE(16'hA5A5))
      u_w0 (.clk(clk), .rst(rst), .a_en(a_en), .a_we(a_we16), .a_addr(a_addr), .a_din(a_din16),
            .a_dout(a_w0), .b_en(b_en), .b_addr(b_addr), .b_dout(b_w0), .busy(busy_w0));
   bram_dp_clr #(.AWIDTH(4), .DWIDTH(16), .BWIDTH(8), .WRMODE(1), .OUT_REG(1), .CLR_VALUE(16'hA5A5))
      u_w1 (.clk(clk), .rst(rst), .a_en(a_en), .a_we(a_we16), .a_addr(a_addr), .a_din(a_din16),
            .a_dout(a_w1), .b_en(b_en), .b_addr(b_addr), .b_dout(b_w1), .busy(busy_w1));

   typedef struct {
      logic       a_en;
      logic       a_we;
      logic [3:0] a_addr;
      logic [7:0] a_din;
      logic       b_en;
      logic [3:0] b_addr;
      logic [7:0] exp_rf;
      logic [7:0] exp_wf;
      logic [7:0] exp_nc;
      logic [7:0] exp_b;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      a_en = 0; b_en = 0; a_we8 = 0; a_we16 = 0;
      a_addr = 0; b_addr = 0; a_din8 = 0; a_din16 = 0;
   endtask

   // Counts edges after rst falls until busy drops (bounded), flagging nonzero douts
   task automatic wait_clear(output int n, output logic dout_nz);
      n = 0;
      dout_nz = 0;
      do begin
         step();
         n++;
         if (busy_rf && ((a_rf | a_wf | a_nc | b_rf | b_wf | b_nc) != 0 ||
                         (a_w0 | a_w1 | b_w0 | b_w1) != 0)) dout_nz = 1;
      end while (busy_rf && n < 40);
   endtask

   int   ncyc;
   logic nz;

   initial begin
      tbl[0] = '{1'b1, 1'b1, 4'd5, 8'h11, 1'b1, 4'd0, 8'hA5, 8'h11, 8'h00, 8'hA5};
      tbl[1] = '{1'b1, 1'b0, 4'd5, 8'h00, 1'b1, 4'd5, 8'h11, 8'h11, 8'h11, 8'h11};
      tbl[2] = '{1'b1, 1'b1, 4'd5, 8'h22, 1'b0, 4'd5, 8'h11, 8'h22, 8'h11, 8'h11};
      tbl[3] = '{1'b1, 1'b0, 4'd5, 8'h00, 1'b1, 4'd5, 8'h22, 8'h22, 8'h22, 8'h22};
      tbl[4] = '{1'b1, 1'b1, 4'd7, 8'h01, 1'b1, 4'd3, 8'hA5, 8'h01, 8'h22, 8'hA5};
      tbl[5] = '{1'b1, 1'b1, 4'd7, 8'h02, 1'b1, 4'd7, 8'h01, 8'h02, 8'h22, 8'h01};
      tbl[6] = '{1'b1, 1'b0, 4'd7, 8'h00, 1'b1, 4'd7, 8'h02, 8'h02, 8'h02, 8'h02};
      tbl[7] = '{1'b0, 1'b1, 4'd7, 8'hFF, 1'b0, 4'd5, 8'h02, 8'h02, 8'h02, 8'h02};
      tbl[8] = '{1'b1, 1'b0, 4'd7, 8'h00, 1'b1, 4'd7, 8'h02, 8'h02, 8'h02, 8'h02};
      tbl[9] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 4'd5, 8'h02, 8'h02, 8'h02, 8'h22};

      // reset and clear sequence
      idle();
      rst = 1;
      step();
      chk("busy_in_reset", {15'd0, busy_rf}, 16'd1);
      chk("douts_in_reset", {8'd0, a_rf | b_rf}, 16'd0);
      rst = 0;
      wait_clear(ncyc, nz);
      chk("clear_cycles", 16'(ncyc), 16'd16);
      chk("douts_zero_busy", {15'd0, nz}, 16'd0);
      chk("busy_all_low", {11'd0, busy_rf, busy_wf, busy_nc, busy_w0, busy_w1}, 16'd0);

      for (int i = 0; i < 16; i++) begin
         b_en = 1; b_addr = 4'(i);
         step();
         chk($sformatf("clr_rf[%0d]", i), {8'd0, b_rf}, 16'h00A5);
         chk($sformatf("clr_w0[%0d]", i), b_w0, 16'hA5A5);
      end
      chk("a_hold_after_clear", {8'd0, a_rf | a_wf | a_nc}, 16'd0);

      // read-during-write, collision and enable vectors
      for (int i = 0; i < 10; i++) begin
         a_en = tbl[i].a_en; a_we8 = tbl[i].a_we; a_addr = tbl[i].a_addr;
         a_din8 = tbl[i].a_din; b_en = tbl[i].b_en; b_addr = tbl[i].b_addr;
         a_we16 = 0;
         step();
         chk($sformatf("v%0d_a_rf", i), {8'd0, a_rf}, {8'd0, tbl[i].exp_rf});
         chk($sformatf("v%0d_a_wf", i), {8'd0, a_wf}, {8'd0, tbl[i].exp_wf});
         chk($sformatf("v%0d_a_nc", i), {8'd0, a_nc}, {8'd0, tbl[i].exp_nc});
         chk($sformatf("v%0d_b", i), {8'd0, b_rf}, {8'd0, tbl[i].exp_b});
         chk($sformatf("v%0d_b_wf", i), {8'd0, b_wf}, {8'd0, tbl[i].exp_b});
      end

      // byte lanes on 16-bit instances
      idle();
      a_en = 1; a_we16 = 2'b11; a_addr = 4'd3; a_din16 = 16'h1234;
      step();
      a_we16 = 2'b10; a_din16 = 16'hABCD;
      step();
      chk("w0_rf_old_word", a_w0, 16'h1234);
      a_en = 0; a_we16 = 0; b_en = 1; b_addr = 4'd3;
      step();
      chk("w0_b_lane", b_w0, 16'hAB34);
      chk("w1_a_wf_merged", a_w1, 16'hAB34);
      chk("w1_b_not_yet", b_w1, 16'hA5A5);
      step();
      chk("w1_b_lane", b_w1, 16'hAB34);

      // reset in the middle of the clear sequence, with writes presented
      idle();
      rst = 1;
      step();
      rst = 0;
      repeat (6) step();
      chk("busy_mid_clear", {15'd0, busy_rf}, 16'd1);
      rst = 1; a_en = 1; a_we8 = 1; a_we16 = 2'b11; a_addr = 4'd2;
      a_din8 = 8'hFF; a_din16 = 16'hFFFF;
      step();
      chk("busy_mid_rst", {15'd0, busy_rf}, 16'd1);
      rst = 0;
      wait_clear(ncyc, nz);
      chk("restart_cycles", 16'(ncyc), 16'd16);
      chk("douts_zero_restart", {15'd0, nz}, 16'd0);
      idle();
      b_en = 1; b_addr = 4'd2;
      step();
      chk("drop_rf", {8'd0, b_rf}, 16'h00A5);
      chk("drop_nc", {8'd0, b_nc}, 16'h00A5);
      chk("drop_w0", b_w0, 16'hA5A5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
